// File: rtl/ext_mem_responder_if.sv
// CPU-side external memory bus: level read/write request in, one-cycle ready/err out.
interface ext_mem_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] i_memory_addr;
  logic [DATA_W-1:0] i_memory_data;
  logic [DATA_W-1:0] o_memory_data;
  logic              i_mem_read;
  logic              i_mem_write;
  logic              o_mem_ready;
  logic              o_mem_err;

  // CPU side drives requests, observes completion
  modport master (
    output i_memory_addr, i_memory_data, i_mem_read, i_mem_write,
    input  o_memory_data, o_mem_ready, o_mem_err
  );

  // Memory side accepts requests, drives completion
  modport slave (
    input  i_memory_addr, i_memory_data, i_mem_read, i_mem_write,
    output o_memory_data, o_mem_ready, o_mem_err
  );
endinterface

// File: rtl/ext_mem_responder.sv
// External memory responder: word RAM with programmable wait states, level request /
// one-cycle ready handshake, and a side loader port usable only while idle.
module ext_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ext_mem_responder_if.slave bus,
  input  logic              i_ctrl_halt,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              is_wr_q;
  logic              err_pend_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic req_c;
  logic both_c;
  logic accept_c;

  // Request decode; loader and halt both gate a new CPU accept in IDLE
  assign req_c    = bus.i_mem_read | bus.i_mem_write;
  assign both_c   = bus.i_mem_read & bus.i_mem_write;
  assign accept_c = (state_q == ST_IDLE) && !i_load_en && !i_ctrl_halt && req_c;

  // Transaction FSM; ready/err/read data are set on the edge entering RESP
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_wr_q    <= 1'b0;
      err_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            addr_q     <= bus.i_memory_addr;
            wdata_q    <= bus.i_memory_data;
            is_wr_q    <= bus.i_mem_write;
            err_pend_q <= both_c;
            cnt_q      <= WAIT_INIT;
            busy_q     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= both_c;
              if (!bus.i_mem_write) begin
                rdata_q <= mem_q[bus.i_memory_addr];
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= err_pend_q;
            if (!is_wr_q) begin
              rdata_q <= mem_q[addr_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold here until the CPU drops its request so it is not re-issued
          if (!req_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM write port: loader in IDLE, CPU write in RESP; nothing is written under reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state_q == ST_IDLE && i_load_en) begin
        mem_q[i_load_addr] <= i_load_data;
      end else if (state_q == ST_RESP && is_wr_q) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

  assign bus.o_memory_data = rdata_q;
  assign bus.o_mem_ready   = ready_q;
  assign bus.o_mem_err     = err_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: three instances (WAIT_CYCLES = 1, 0, 3) driven by
// directed and random transactions, checked against a transaction-level memory model.
module tb_ext_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [2:0][7:0]  addr_v;
  logic [2:0][15:0] wdata_v;
  logic [2:0]       rd_v;
  logic [2:0]       wr_v;
  logic [2:0]       halt_v;
  logic [2:0]       ld_v;
  logic [2:0][7:0]  laddr_v;
  logic [2:0][15:0] ldata_v;
  logic [2:0][15:0] rdata_v;
  logic [2:0]       rdy_v;
  logic [2:0]       err_v;
  logic [2:0]       busy_v;

  int WAITS [3] = '{1, 0, 3};

  // Instance g uses WAIT_CYCLES = WAITS[g]
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    ext_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    assign bus.i_memory_addr = addr_v[g];
    assign bus.i_memory_data = wdata_v[g];
    assign bus.i_mem_read    = rd_v[g];
    assign bus.i_mem_write   = wr_v[g];
    assign rdata_v[g]        = bus.o_memory_data;
    assign rdy_v[g]          = bus.o_mem_ready;
    assign err_v[g]          = bus.o_mem_err;
    ext_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(WC)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus),
      .i_ctrl_halt (halt_v[g]),
      .i_load_en   (ld_v[g]),
      .i_load_addr (laddr_v[g]),
      .i_load_data (ldata_v[g]),
      .o_busy      (busy_v[g])
    );
  end

  // Reference model: memory contents per instance, which words are known, last read value
  logic [15:0] mem_m [3][256];
  bit          known [3][256];
  logic [15:0] last_rd [3];
  bit          last_ok [3];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 3));
    return 8'(8'd252 + 8'($urandom_range(0, 3)));
  endfunction

  task automatic load(input int k, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_v[k] = 1'b1; laddr_v[k] = a; ldata_v[k] = d;
    @(negedge clk);
    ld_v[k] = 1'b0;
    mem_m[k][a] = d;
    known[k][a] = 1'b1;
  endtask

  // Request inputs were set at the previous negedge; wait for ready and check the response
  task automatic finish_req(input int k, input bit rd, input bit wr, input logic [7:0] a,
                            input logic [15:0] d, input int hold);
    int c;
    bit got;
    int h;
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (rdy_v[k]) got = 1'b1;
      else begin
        // Accepted already: bus changes, halt and loader strobes must all be ignored
        addr_v[k]  = 8'($urandom);
        wdata_v[k] = 16'($urandom);
        halt_v[k]  = 1'($urandom);
        ld_v[k]    = 1'($urandom);
        laddr_v[k] = pick_addr();
        ldata_v[k] = 16'($urandom);
      end
    end
    halt_v[k] = 1'b0;
    ld_v[k]   = 1'b0;
    check("ready_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(c), 32'(WAITS[k] + 1));
      check("err_flag", 32'(err_v[k]), 32'(rd & wr));
      if (wr) begin
        if (last_ok[k]) check("rdata_hold", 32'(rdata_v[k]), 32'(last_rd[k]));
        mem_m[k][a] = d;
        known[k][a] = 1'b1;
      end else begin
        if (known[k][a]) check("rdata", 32'(rdata_v[k]), 32'(mem_m[k][a]));
        last_ok[k] = known[k][a];
        last_rd[k] = mem_m[k][a];
      end
    end
    h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      check("no_double_ready", 32'(rdy_v[k]), 32'd0);
    end
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
    @(negedge clk);
    check("ready_after_drop", 32'(rdy_v[k]), 32'd0);
    @(negedge clk);
    check("idle_after_drop", 32'(busy_v[k]), 32'd0);
  endtask

  task automatic do_req(input int k, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, input int hold);
    @(negedge clk);
    addr_v[k] = a; wdata_v[k] = d; rd_v[k] = rd; wr_v[k] = wr;
    finish_req(k, rd, wr, a, d, hold);
  endtask

  initial begin
    int op;
    logic [7:0] ra;
    logic [15:0] rdat;

    rst_n = 1'b0;
    addr_v = '0; wdata_v = '0; rd_v = '0; wr_v = '0;
    halt_v = '0; ld_v = '0; laddr_v = '0; ldata_v = '0;
    for (int k = 0; k < 3; k++) begin
      last_ok[k] = 1'b1;
      last_rd[k] = 16'h0;
      for (int j = 0; j < 256; j++) known[k][j] = 1'b0;
    end

    // Reset state on every instance
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rdata", 32'(rdata_v[k]), 32'd0);
      check("rst_ready", 32'(rdy_v[k]), 32'd0);
      check("rst_err", 32'(err_v[k]), 32'd0);
      check("rst_busy", 32'(busy_v[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Load while halted; a read under halt is blocked, then served once halt drops
    halt_v[0] = 1'b1;
    load(0, 8'h10, 16'hBEEF);
    @(negedge clk);
    rd_v[0] = 1'b1; addr_v[0] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_blocks_ready", 32'(rdy_v[0]), 32'd0);
      check("halt_blocks_busy", 32'(busy_v[0]), 32'd0);
    end
    halt_v[0] = 1'b0;
    finish_req(0, 1'b1, 1'b0, 8'h10, 16'h0, -1);

    // Write then read back at the top address
    do_req(0, 1'b0, 1'b1, 8'hFF, 16'h1234, 0);
    do_req(0, 1'b1, 1'b0, 8'hFF, 16'h0, 0);

    // Zero wait states, request held 5 cycles past ready
    load(1, 8'h40, 16'h0F0F);
    do_req(1, 1'b1, 1'b0, 8'h40, 16'h0, 5);

    // Read and write together: treated as write with an error pulse
    do_req(0, 1'b1, 1'b1, 8'h20, 16'h5555, -1);
    do_req(0, 1'b1, 1'b0, 8'h20, 16'h0, -1);

    // Reset during WAIT aborts a write
    do_req(2, 1'b0, 1'b1, 8'h30, 16'hAAAA, -1);
    @(negedge clk);
    addr_v[2] = 8'h30; wdata_v[2] = 16'h1111; wr_v[2] = 1'b1;
    @(negedge clk);
    check("t5_busy_in_wait", 32'(busy_v[2]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy_after_rst", 32'(busy_v[2]), 32'd0);
    check("t5_ready_after_rst", 32'(rdy_v[2]), 32'd0);
    check("t5_rdata_after_rst", 32'(rdata_v[0]), 32'd0);
    rst_n = 1'b1;
    wr_v[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      last_ok[k] = 1'b1;
      last_rd[k] = 16'h0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_ready", 32'(rdy_v[2]), 32'd0);
    end
    do_req(2, 1'b1, 1'b0, 8'h30, 16'h0, -1);

    // Loader and CPU read together: load wins, read served after load drops
    @(negedge clk);
    ld_v[0] = 1'b1; laddr_v[0] = 8'h50; ldata_v[0] = 16'hC0DE;
    rd_v[0] = 1'b1; addr_v[0] = 8'h50;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_load_defers_ready", 32'(rdy_v[0]), 32'd0);
      check("t6_load_defers_busy", 32'(busy_v[0]), 32'd0);
    end
    ld_v[0] = 1'b0;
    mem_m[0][8'h50] = 16'hC0DE;
    known[0][8'h50] = 1'b1;
    finish_req(0, 1'b1, 1'b0, 8'h50, 16'h0, -1);

    // Random traffic on all instances
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        op   = int'($urandom_range(0, 9));
        ra   = pick_addr();
        rdat = 16'($urandom);
        if ($urandom_range(0, 3) == 0) load(k, pick_addr(), 16'($urandom));
        do_req(k, (op < 5) || (op == 9), op >= 5, ra, rdat, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
